regf_write_arbiter: RTL and testbench

REGF_WRITE_ARBITER -- requirements
Module: regf_write_arbiter

---
 rtl/regf_write_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_regf_write_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regf_write_arbiter.sv
// Register-file write arbiter: picks one of mem/alu/mv writers per cycle with age-based
// starvation override, issues the op one cycle later and tracks pending targets for hazard checks.
module regf_write_arbiter #(
  parameter int AGE_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       freeze,
  input  logic       alu_req,
  input  logic       alu_to_acc,
  input  logic [3:0] alu_addr,
  input  logic [7:0] alu_data,
  input  logic       mem_req,
  input  logic [3:0] mem_addr,
  input  logic [7:0] mem_data,
  input  logic       mv_req,
  input  logic       mv_dir,
  input  logic [3:0] mv_reg,
  input  logic [3:0] raddr1,
  input  logic [3:0] raddr2,
  output logic       alu_gnt,
  output logic       mem_gnt,
  output logic       mv_gnt,
  output logic       rf_write_en,
  output logic       rf_acc,
  output logic       rf_mar,
  output logic       rf_mra,
  output logic [3:0] rf_waddr,
  output logic [7:0] rf_wdata,
  output logic       hz1,
  output logic       hz2,
  output logic [7:0] wr_count
);

  localparam int         NREQ     = 3;
  localparam logic [2:0] AGE_LIM  = 3'(AGE_LIMIT);
  localparam logic [2:0] AGE_MAX  = 3'd7;
  localparam logic [3:0] ZERO_REG = 4'd0;
  localparam logic [3:0] ACC_REG  = 4'd2;

  // Requester index doubles as default priority: 0 = mem, 1 = alu, 2 = mv.
  logic [NREQ-1:0]   req_vec;
  logic [NREQ-1:0]   gnt_vec;
  logic [3*NREQ-1:0] age_flat;
  logic              aged;
  logic              found;
  logic [2:0]        best_age;
  logic [1:0]        win_idx;
  logic              grant_any;

  logic       iss_valid;
  logic       iss_we;
  logic       iss_acc;
  logic       iss_mar;
  logic       iss_mra;
  logic [3:0] iss_addr;
  logic [7:0] iss_data;
  logic [3:0] iss_busy_bit;

  logic        rf_write_en_reg;
  logic        rf_acc_reg;
  logic        rf_mar_reg;
  logic        rf_mra_reg;
  logic [3:0]  rf_waddr_reg;
  logic [7:0]  rf_wdata_reg;
  logic [15:0] busy_reg;
  logic [7:0]  wr_count_reg;

  assign req_vec = {mv_req, alu_req, mem_req};

  always_comb begin
    aged     = 1'b0;
    found    = 1'b0;
    best_age = '0;
    win_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_vec[i] && (age_flat[i*3 +: 3] >= AGE_LIM)) aged = 1'b1;
    end
    // Strict '>' keeps ties with the earlier (higher default priority) requester.
    for (int i = 0; i < NREQ; i++) begin
      if (req_vec[i] && (!found || (aged && (age_flat[i*3 +: 3] > best_age)))) begin
        found    = 1'b1;
        best_age = age_flat[i*3 +: 3];
        win_idx  = 2'(i);
      end
    end
  end

  assign grant_any = rst_n & ~freeze & (|req_vec);
  assign gnt_vec   = grant_any ? (3'b001 << win_idx) : '0;
  assign mem_gnt   = gnt_vec[0];
  assign alu_gnt   = gnt_vec[1];
  assign mv_gnt    = gnt_vec[2];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_age
      logic [2:0] age_reg;
      logic [2:0] age_next;

      always_comb begin
        age_next = age_reg;
        if (!freeze) begin
          if (!req_vec[gi] || gnt_vec[gi]) age_next = '0;
          else if (age_reg != AGE_MAX)     age_next = age_reg + 3'd1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) age_reg <= '0;
        else        age_reg <= age_next;
      end

      assign age_flat[gi*3 +: 3] = age_reg;
    end
  endgenerate

  // Writes to $zero and moves touching $acc on both sides are acknowledged but discarded.
  always_comb begin
    iss_valid    = 1'b0;
    iss_we       = 1'b0;
    iss_acc      = 1'b0;
    iss_mar      = 1'b0;
    iss_mra      = 1'b0;
    iss_addr     = '0;
    iss_data     = '0;
    iss_busy_bit = '0;
    if (grant_any) begin
      case (win_idx)
        2'd0: begin
          if (mem_addr != ZERO_REG) begin
            iss_valid    = 1'b1;
            iss_we       = 1'b1;
            iss_addr     = mem_addr;
            iss_data     = mem_data;
            iss_busy_bit = mem_addr;
          end
        end
        2'd1: begin
          if (alu_to_acc) begin
            iss_valid    = 1'b1;
            iss_we       = 1'b1;
            iss_acc      = 1'b1;
            iss_addr     = ACC_REG;
            iss_data     = alu_data;
            iss_busy_bit = ACC_REG;
          end else if (alu_addr != ZERO_REG) begin
            iss_valid    = 1'b1;
            iss_we       = 1'b1;
            iss_addr     = alu_addr;
            iss_data     = alu_data;
            iss_busy_bit = alu_addr;
          end
        end
        default: begin
          if (mv_reg != ACC_REG) begin
            iss_valid    = 1'b1;
            iss_mar      = ~mv_dir;
            iss_mra      = mv_dir;
            iss_addr     = mv_reg;
            iss_data     = '0;
            iss_busy_bit = mv_dir ? ACC_REG : mv_reg;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_en_reg <= 1'b0;
      rf_acc_reg      <= 1'b0;
      rf_mar_reg      <= 1'b0;
      rf_mra_reg      <= 1'b0;
      rf_waddr_reg    <= '0;
      rf_wdata_reg    <= '0;
      busy_reg        <= '0;
      wr_count_reg    <= '0;
    end else begin
      rf_write_en_reg <= iss_we;
      rf_acc_reg      <= iss_acc;
      rf_mar_reg      <= iss_mar;
      rf_mra_reg      <= iss_mra;
      // Only the op being issued next cycle is pending, so busy is rebuilt every edge.
      busy_reg        <= iss_valid ? (16'd1 << iss_busy_bit) : '0;
      if (iss_valid) begin
        rf_waddr_reg <= iss_addr;
        rf_wdata_reg <= iss_data;
        wr_count_reg <= wr_count_reg + 8'd1;
      end
    end
  end

  assign rf_write_en = rf_write_en_reg;
  assign rf_acc      = rf_acc_reg;
  assign rf_mar      = rf_mar_reg;
  assign rf_mra      = rf_mra_reg;
  assign rf_waddr    = rf_waddr_reg;
  assign rf_wdata    = rf_wdata_reg;
  assign wr_count    = wr_count_reg;
  assign hz1         = busy_reg[raddr1];
  assign hz2         = busy_reg[raddr2];

endmodule

// File: tb/tb_regf_write_arbiter.sv
// Bench for regf_write_arbiter: per-cycle comparison against a behavioural model plus
// hand-computed directed expectations.
module tb_regf_write_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       freeze;
  logic       alu_req, alu_to_acc;
  logic [3:0] alu_addr;
  logic [7:0] alu_data;
  logic       mem_req;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       mv_req, mv_dir;
  logic [3:0] mv_reg;
  logic [3:0] raddr1, raddr2;
  logic       alu_gnt, mem_gnt, mv_gnt;
  logic       rf_write_en, rf_acc, rf_mar, rf_mra;
  logic [3:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       hz1, hz2;
  logic [7:0] wr_count;

  localparam int AGE_LIMIT = 3;

  regf_write_arbiter #(.AGE_LIMIT(AGE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze),
    .alu_req(alu_req), .alu_to_acc(alu_to_acc), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .mv_req(mv_req), .mv_dir(mv_dir), .mv_reg(mv_reg),
    .raddr1(raddr1), .raddr2(raddr2),
    .alu_gnt(alu_gnt), .mem_gnt(mem_gnt), .mv_gnt(mv_gnt),
    .rf_write_en(rf_write_en), .rf_acc(rf_acc), .rf_mar(rf_mar), .rf_mra(rf_mra),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hz1(hz1), .hz2(hz2), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: expected register-file state visible during the current cycle.
  logic        m_we = 0, m_acc = 0, m_mar = 0, m_mra = 0;
  logic [3:0]  m_waddr = 0;
  logic [7:0]  m_wdata = 0;
  logic [15:0] m_busy = 0;
  logic [7:0]  m_cnt = 0;
  int          ages[3] = '{0, 0, 0};
  logic [2:0]  reqs;
  int          win, oldest, score, best;
  string       names[3] = '{"mem", "alu", "mv"};

  task automatic model_issue(input logic we, input logic acc, input logic mar, input logic mra,
                             input logic [3:0] addr, input logic [7:0] data, input logic [3:0] tgt);
    m_we = we; m_acc = acc; m_mar = mar; m_mra = mra;
    m_waddr = addr; m_wdata = data;
    m_busy[tgt] = 1'b1;
    m_cnt = m_cnt + 8'd1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_we = 0; m_acc = 0; m_mar = 0; m_mra = 0;
        m_waddr = 0; m_wdata = 0; m_busy = 0; m_cnt = 0;
        for (int i = 0; i < 3; i++) ages[i] = 0;
      end
      reqs = {mv_req, alu_req, mem_req};
      win = -1;
      if (rst_n && !freeze) begin
        oldest = 0;
        for (int i = 0; i < 3; i++) if (reqs[i] && ages[i] > oldest) oldest = ages[i];
        best = -1;
        for (int i = 0; i < 3; i++) begin
          if (reqs[i]) begin
            score = (oldest >= AGE_LIMIT) ? ages[i] * 4 + (3 - i) : (3 - i);
            if (score > best) begin best = score; win = i; end
          end
        end
      end
      check("m_mem_gnt", mem_gnt, win == 0);
      check("m_alu_gnt", alu_gnt, win == 1);
      check("m_mv_gnt", mv_gnt, win == 2);
      check("m_rf_write_en", rf_write_en, m_we);
      check("m_rf_acc", rf_acc, m_acc);
      check("m_rf_mar", rf_mar, m_mar);
      check("m_rf_mra", rf_mra, m_mra);
      check("m_rf_waddr", rf_waddr, m_waddr);
      check("m_rf_wdata", rf_wdata, m_wdata);
      check("m_hz1", hz1, m_busy[raddr1]);
      check("m_hz2", hz2, m_busy[raddr2]);
      check("m_wr_count", wr_count, m_cnt);
      check("m_rf_excl", $countones({rf_write_en, rf_mar, rf_mra}) <= 1, 1'b1);
      if (win >= 0) $display("t=%0t grant %s wr_count=%0d", $time, names[win], wr_count);
      if (rst_n) begin
        m_we = 0; m_acc = 0; m_mar = 0; m_mra = 0; m_busy = 0;
        if (win == 0 && mem_addr != 0)
          model_issue(1, 0, 0, 0, mem_addr, mem_data, mem_addr);
        else if (win == 1 && alu_to_acc)
          model_issue(1, 1, 0, 0, 4'd2, alu_data, 4'd2);
        else if (win == 1 && alu_addr != 0)
          model_issue(1, 0, 0, 0, alu_addr, alu_data, alu_addr);
        else if (win == 2 && mv_reg != 2)
          model_issue(0, 0, !mv_dir, mv_dir, mv_reg, 8'h00, mv_dir ? 4'd2 : mv_reg);
        if (!freeze)
          for (int i = 0; i < 3; i++)
            ages[i] = (!reqs[i] || win == i) ? 0 : (ages[i] < 7 ? ages[i] + 1 : 7);
      end
    end
  end

  initial begin
    rst_n = 0; freeze = 0;
    alu_req = 0; alu_to_acc = 0; alu_addr = 0; alu_data = 0;
    mem_req = 1; mem_addr = 4'd1; mem_data = 8'h01;
    mv_req = 0; mv_dir = 0; mv_reg = 0;
    raddr1 = 4'd5; raddr2 = 4'd2;

    tick();
    check("rst_mem_gnt", mem_gnt, 0);
    check("rst_we", rf_write_en, 0);
    check("rst_count", wr_count, 0);
    tick();
    rst_n = 1; mem_req = 0;
    tick();

    // mem beats alu; hazard on the pending mem target
    mem_req = 1; mem_addr = 4'd5; mem_data = 8'h3C;
    alu_req = 1; alu_addr = 4'd7; alu_data = 8'h11;
    #1;
    check("pri_mem_gnt", mem_gnt, 1);
    check("pri_alu_gnt", alu_gnt, 0);
    tick();
    mem_req = 0;
    #1;
    check("mem_we", rf_write_en, 1);
    check("mem_waddr", rf_waddr, 5);
    check("mem_wdata", rf_wdata, 8'h3C);
    check("mem_hz1", hz1, 1);
    check("alu_gnt_late", alu_gnt, 1);
    tick();
    alu_req = 0;
    #1;
    check("alu_we", rf_write_en, 1);
    check("alu_waddr", rf_waddr, 7);
    check("alu_wdata", rf_wdata, 8'h11);
    check("alu_hz1_clear", hz1, 0);
    check("count_2", wr_count, 2);
    tick();
    check("idle_we", rf_write_en, 0);
    check("idle_waddr_hold", rf_waddr, 7);

    // writes to $zero and mv to $acc are granted but dropped
    tick();
    alu_req = 1; alu_addr = 4'd0; alu_data = 8'h55;
    #1;
    check("zero_alu_gnt", alu_gnt, 1);
    tick();
    alu_req = 0;
    #1;
    check("zero_no_we", rf_write_en, 0);
    check("zero_count", wr_count, 2);
    mv_req = 1; mv_dir = 0; mv_reg = 4'd2;
    #1;
    check("mv2_gnt", mv_gnt, 1);
    tick();
    mv_req = 0;
    #1;
    check("mv2_no_mar", rf_mar, 0);
    check("mv2_count", wr_count, 2);

    // starvation: mv wins on its 4th waiting cycle against a continuous mem stream
    tick();
    mem_req = 1; mem_addr = 4'd3; mem_data = 8'h40;
    mv_req = 1; mv_dir = 1; mv_reg = 4'd9;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("age_mem_gnt", mem_gnt, k < 3);
      check("age_mv_gnt", mv_gnt, k == 3);
      tick();
    end
    mv_req = 0;
    #1;
    check("mra_pulse", rf_mra, 1);
    check("mra_no_mar", rf_mar, 0);
    check("mra_no_we", rf_write_en, 0);
    check("mra_waddr", rf_waddr, 9);
    check("mra_wdata", rf_wdata, 0);
    check("mra_hz_acc", hz2, 1);
    check("mra_count", wr_count, 6);
    check("mem_after_mv", mem_gnt, 1);
    tick();
    mem_req = 0;
    #1;
    check("mem3_waddr", rf_waddr, 3);
    check("count_7", wr_count, 7);

    // freeze: issue in progress survives, grants blocked, ages held
    tick();
    mem_req = 1; mem_addr = 4'd6; mem_data = 8'h66;
    alu_req = 1; alu_addr = 4'd4; alu_data = 8'h44;
    #1;
    check("pre_freeze_mem", mem_gnt, 1);
    tick();
    freeze = 1;
    #1;
    check("frz_issue_we", rf_write_en, 1);
    check("frz_issue_waddr", rf_waddr, 6);
    check("frz_count", wr_count, 8);
    for (int k = 0; k < 5; k++) begin
      check("frz_alu_gnt", alu_gnt, 0);
      check("frz_mem_gnt", mem_gnt, 0);
      if (k < 4) begin tick(); #1; end
    end
    tick();
    freeze = 0;
    #1;
    check("unfrz_c0_mem", mem_gnt, 1);
    tick();
    #1;
    check("unfrz_c1_mem", mem_gnt, 1);
    tick();
    #1;
    check("unfrz_c2_alu", alu_gnt, 1);
    tick();
    mem_req = 0; alu_req = 0; raddr1 = 4'd4;
    #1;
    check("alu4_we", rf_write_en, 1);
    check("alu4_waddr", rf_waddr, 4);
    check("alu4_hz1", hz1, 1);
    check("count_11", wr_count, 11);

    // reset mid-issue clears everything immediately
    rst_n = 0;
    #1;
    check("rstmid_we", rf_write_en, 0);
    check("rstmid_waddr", rf_waddr, 0);
    check("rstmid_wdata", rf_wdata, 0);
    check("rstmid_hz1", hz1, 0);
    check("rstmid_count", wr_count, 0);
    tick();
    rst_n = 1;

    // $acc writes and counter wrap after 256 issues
    tick();
    alu_req = 1; alu_to_acc = 1; alu_addr = 4'd9; alu_data = 8'h81;
    #1;
    check("acc_gnt", alu_gnt, 1);
    tick();
    check("acc_we", rf_write_en, 1);
    check("acc_flag", rf_acc, 1);
    check("acc_waddr", rf_waddr, 2);
    check("acc_wdata", rf_wdata, 8'h81);
    check("acc_hz2", hz2, 1);
    check("acc_count_1", wr_count, 1);
    repeat (255) tick();
    alu_req = 0;
    #1;
    check("wrap_we", rf_write_en, 1);
    check("wrap_count", wr_count, 0);
    tick();
    check("wrap_idle_we", rf_write_en, 0);
    check("wrap_idle_count", wr_count, 0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
